// File: rtl/encoder_pkg.sv
// Shared types and helpers for the 8-to-3 request scheduler.
package encoder_pkg;

  localparam int unsigned N_IN  = 8;
  localparam int unsigned IDX_W = $clog2(N_IN);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic logic [N_IN-1:0] onehot8(input logic [IDX_W-1:0] idx);
    logic [N_IN-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-input priority encoder searching upward from base, wrapping 7 to 0.
module prio_enc8
  import encoder_pkg::*;
(
  input  logic [N_IN-1:0]  vec,
  input  logic [IDX_W-1:0] base,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    idx = '0;
    pos = '0;
    // Scan from the farthest offset down so the nearest set bit is assigned last.
    for (int i = N_IN - 1; i >= 0; i--) begin
      pos = base + IDX_W'(i);
      if (vec[pos]) begin
        idx = pos;
      end
    end
    any = |vec;
  end

endmodule

// File: rtl/encoder8_3_sched.sv
// Captures multi-hot requests into a pending vector and issues them one index at a time
// on a valid/ready port. Define ENCODER8_3_ROUND_ROBIN_EN for round-robin selection.
module encoder8_3_sched
  import encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_IN-1:0]  req,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_IN-1:0]  pending,
  output logic             dup_err
);

  state_t           state_q, state_d;
  logic [N_IN-1:0]  pending_q, pending_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dup_q, dup_d;

  logic             accept;
  logic [N_IN-1:0]  clr;
  logic [N_IN-1:0]  rem;
  logic [N_IN-1:0]  set;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;

  assign accept = (state_q == PRESENT) & out_ready;
  assign clr    = accept ? onehot8(idx_q) : '0;
  // In IDLE clr is zero, so rem doubles as the pending vector for the initial load.
  assign rem    = pending_q & ~clr;
  assign set    = en ? req : '0;

`ifdef ENCODER8_3_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last_q, last_d;

  // On accept the granted index becomes the new last grant, so search past it directly.
  assign base   = accept ? (idx_q + 3'd1) : (last_q + 3'd1);
  assign last_d = accept ? idx_q : last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 3'd7;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign base = '0;
`endif

  prio_enc8 u_select (
    .vec  (rem),
    .base (base),
    .idx  (sel_idx),
    .any  (sel_any)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = rem | set;
    dup_d     = dup_q | (|(set & rem));
    case (state_q)
      IDLE: begin
        if (sel_any) begin
          idx_d   = sel_idx;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (accept) begin
          if (sel_any) begin
            idx_d = sel_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      dup_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      dup_q     <= dup_d;
    end
  end

  assign out_idx   = idx_q;
  assign out_valid = (state_q == PRESENT);
  assign pending   = pending_q;
  assign dup_err   = dup_q;

endmodule

// File: tb/tb_encoder8_3_sched.sv
// Self-checking bench for encoder8_3_sched: directed pins plus randomized traffic vs a model.
module tb_encoder8_3_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [2:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic       dup_err;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  encoder8_3_sched dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .dup_err   (dup_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit [7:0] m_pend;
  bit       m_valid;
  int       m_idx;
  bit       m_dup;
  int       m_last;

  function automatic int pick(input bit [7:0] v, input int start);
    for (int k = 0; k < 8; k++) begin
      int b;
      b = (start + k) % 8;
      if (v[b]) return b;
    end
    return 0;
  endfunction

  function automatic int start_after(input int last);
`ifdef ENCODER8_3_ROUND_ROBIN_EN
    return (last + 1) % 8;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pend  = 8'h00;
      m_valid = 1'b0;
      m_idx   = 0;
      m_dup   = 1'b0;
      m_last  = 7;
    end else begin
      bit       acc;
      bit [7:0] rem;
      bit [7:0] setv;
      acc  = m_valid && out_ready;
      rem  = m_pend;
      if (acc) rem[m_idx] = 1'b0;
      setv = en ? req : 8'h00;
      if ((setv & rem) != 0) m_dup = 1'b1;
      if (!m_valid) begin
        if (m_pend != 0) begin
          m_idx   = pick(m_pend, start_after(m_last));
          m_valid = 1'b1;
        end
      end else if (acc) begin
        m_last = m_idx;
        if (rem != 0) m_idx = pick(rem, start_after(m_last));
        else m_valid = 1'b0;
      end
      m_pend = rem | setv;
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("m_valid", int'(out_valid), int'(m_valid));
      cmp("m_idx", int'(out_idx), m_idx);
      cmp("m_pending", int'(pending), int'(m_pend));
      cmp("m_dup", int'(dup_err), int'(m_dup));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!out_valid && n < max) begin
      tick();
      n++;
    end
    if (!out_valid) cmp("timeout_valid", 0, 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 8'h00; out_ready = 1'b0;
    tick();
    tick();
    chk_on = 1'b1;
    rst = 1'b0;
    cmp("rst_valid", int'(out_valid), 0);
    cmp("rst_idx", int'(out_idx), 0);
    cmp("rst_pending", int'(pending), 0);
    cmp("rst_dup", int'(dup_err), 0);

    // Single request: two-cycle latency, then cleared on accept
    en = 1'b1; out_ready = 1'b1; req = 8'h04;
    tick(); req = 8'h00;
    cmp("t1_pending", int'(pending), 8'h04);
    cmp("t1_novalid", int'(out_valid), 0);
    tick();
    cmp("t1_valid", int'(out_valid), 1);
    cmp("t1_idx", int'(out_idx), 2);
    tick();
    cmp("t1_done", int'(out_valid), 0);
    cmp("t1_clear", int'(pending), 0);

    // Multi-hot burst drains back to back
    req = 8'h92;
    tick(); req = 8'h00;
    tick(); cmp("t2_idx1", int'(out_idx), 1); cmp("t2_v1", int'(out_valid), 1);
    tick(); cmp("t2_idx4", int'(out_idx), 4);
    tick(); cmp("t2_idx7", int'(out_idx), 7);
    tick(); cmp("t2_end", int'(out_valid), 0);

    // Stall, duplicate while presented, then re-request in the accept cycle
    out_ready = 1'b0; req = 8'h08;
    tick(); req = 8'h00;
    tick(); cmp("t3_idx", int'(out_idx), 3);
    for (int i = 0; i < 4; i++) begin
      tick();
      cmp("t3_hold_valid", int'(out_valid), 1);
      cmp("t3_hold_idx", int'(out_idx), 3);
    end
    cmp("t3_nodup", int'(dup_err), 0);
    req = 8'h08;
    tick(); req = 8'h00;
    cmp("t3_dup", int'(dup_err), 1);
    out_ready = 1'b1; req = 8'h08;
    tick(); req = 8'h00;
    cmp("t3_acc_valid", int'(out_valid), 0);
    cmp("t3_acc_pend", int'(pending), 8'h08);
    tick();
    cmp("t3_reissue", int'(out_valid), 1);
    cmp("t3_reissue_idx", int'(out_idx), 3);
    tick();
    cmp("t3_one_acc", int'(out_valid), 0);
    cmp("t3_dup_sticky", int'(dup_err), 1);

    // Capture disabled
    rst = 1'b1;
    tick(); rst = 1'b0;
    cmp("t4_dup_clr", int'(dup_err), 0);
    en = 1'b0; req = 8'hFF;
    tick(); tick(); tick();
    cmp("t4_pend", int'(pending), 0);
    cmp("t4_valid", int'(out_valid), 0);
    en = 1'b1; req = 8'h00;

    // Reset mid-handshake
    out_ready = 1'b0; req = 8'h30;
    tick(); req = 8'h00;
    wait_valid(4);
    cmp("t5_pend", int'(pending), 8'h30);
    cmp("t5_idx", int'(out_idx), 4);
    rst = 1'b1;
    tick(); rst = 1'b0;
    cmp("t5_valid", int'(out_valid), 0);
    cmp("t5_pend0", int'(pending), 0);
    cmp("t5_idx0", int'(out_idx), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 79) == 0);
      en        = ($urandom_range(0, 3) != 0);
      req       = 8'($urandom & $urandom & $urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    // Saturated requests: rotation in round-robin, lowest-pair alternation otherwise
    rst = 1'b1; req = 8'h00;
    tick(); rst = 1'b0;
    en = 1'b1; out_ready = 1'b1; req = 8'hFF;
    tick();
    wait_valid(4);
    for (int i = 0; i < 10; i++) begin
`ifdef ENCODER8_3_ROUND_ROBIN_EN
      cmp("sat_rr_idx", int'(out_idx), i % 8);
`else
      cmp("sat_fixed_idx", int'(out_idx), i % 2);
`endif
      tick();
    end
    req = 8'h00;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
